// File: rtl/rip_bram_lsu_port.sv
// Load/store front end for the read/write port of a byte-writable BRAM.
// Converts byte/half/word requests to word accesses and returns aligned, extended load data.
module rip_bram_lsu_port #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mem_enable,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [3:0]              mem_we,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  req_err;
  logic [3:0]            we_mask;
  logic [DATA_WIDTH-1:0] din_rep;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] lane_shift;
  logic [15:0]           half_sel;

  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    we_mask = 4'b1111;
    din_rep = req_wdata;
    case (req_size)
      2'b00: begin
        we_mask = 4'b0001 << req_addr[1:0];
        din_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        we_mask = 4'b0011 << req_addr[1:0];
        din_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction uses the offset latched at accept; mem_dout is valid in RD_WAIT.
  assign lane_shift = mem_dout >> {off_q, 3'b000};
  assign half_sel   = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];

  always_comb begin
    load_ext = mem_dout;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, lane_shift[7:0]} : {{24{lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   load_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    mem_enable = 1'b0;
    mem_addr   = '0;
    mem_we     = 4'b0000;
    mem_din    = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = ~rst;
        if (req_valid && !rst) begin
          mem_addr = req_addr[ADDR_WIDTH+1:2];
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end else if (req_we) begin
            mem_enable = 1'b1;
            mem_we     = we_mask;
            mem_din    = din_rep;
            err_d      = 1'b0;
            rdata_d    = '0;
            state_d    = StResp;
          end else begin
            mem_enable = 1'b1;
            off_d      = req_addr[1:0];
            size_d     = req_size;
            uns_d      = req_unsigned;
            state_d    = StRdWait;
          end
        end
      end
      StRdWait: begin
        rdata_d = load_ext;
        err_d   = 1'b0;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_rip_bram_lsu_port.sv
// Directed scoreboard bench for rip_bram_lsu_port with a behavioural byte-writable BRAM.
module tb_rip_bram_lsu_port;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW+1:0] req_addr;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_enable;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [32:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rip_bram_lsu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_enable) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr][i*8 +: 8] <= mem_din[i*8 +: 8];
      mem_dout <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake and checks hold behaviour.
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [32:0] prev_resp  = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", {31'b0, resp_valid}, 32'd1);
        chk("hold_resp", {resp_err, resp_rdata}, prev_resp[31:0]);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got err=%b rdata=%h expected none", resp_err, resp_rdata);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
          chk("resp_rdata", resp_rdata, e[31:0]);
        end
      end
    end
    prev_valid = resp_valid & ~rst;
    prev_ready = resp_ready;
    prev_resp  = {1'b0, resp_err, resp_rdata[30:0]} ^ {2'b0, resp_rdata[31], 30'b0};
    prev_resp  = {1'b0, resp_err ^ resp_rdata[31], resp_rdata[30:0]};
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW+1:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  // One transaction with resp_ready held high; checks accept-cycle port outputs and latency.
  task automatic txn(input string name, input logic we, input logic [1:0] size, input logic uns,
                     input logic [AW+1:0] addr, input logic [31:0] wdata, input logic exp_err,
                     input logic [31:0] exp_rdata, input logic [3:0] exp_we,
                     input logic [31:0] exp_din);
    int lat;
    drive(we, size, uns, addr, wdata);
    @(negedge clk);
    chk({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    chk({name, "_en"}, {31'b0, mem_enable}, {31'b0, ~exp_err});
    chk({name, "_we"}, {28'b0, mem_we}, {28'b0, exp_we});
    if (!exp_err) chk({name, "_addr"}, {22'b0, mem_addr}, {22'b0, addr[AW+1:2]});
    if (we && !exp_err) chk({name, "_din"}, mem_din, exp_din);
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk({name, "_lat"}, lat, (we || exp_err) ? 32'd1 : 32'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_enable}, 32'd0);
    chk("rst_mem_we", {28'b0, mem_we}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("idle_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;

    // Stores
    txn("sw",  1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF);
    txn("sh",  1, 2'b01, 0, 12'h012, 32'h00001234, 0, 32'h0, 4'b1100, 32'h12341234);
    txn("lw1", 0, 2'b10, 0, 12'h010, 32'h0,        0, 32'h1234BEEF, 4'b0000, 32'h0);
    txn("sw2", 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF);
    txn("sb",  1, 2'b00, 0, 12'h013, 32'hFFFFFFA5, 0, 32'h0, 4'b1000, 32'hA5A5A5A5);
    // Loads from 0xA5ADBEEF
    txn("lb",  0, 2'b00, 0, 12'h013, 32'h0, 0, 32'hFFFFFFA5, 4'b0000, 32'h0);
    txn("lbu", 0, 2'b00, 1, 12'h013, 32'h0, 0, 32'h000000A5, 4'b0000, 32'h0);
    txn("lh",  0, 2'b01, 0, 12'h012, 32'h0, 0, 32'hFFFFA5AD, 4'b0000, 32'h0);
    txn("lhu", 0, 2'b01, 1, 12'h012, 32'h0, 0, 32'h0000A5AD, 4'b0000, 32'h0);
    txn("lw",  0, 2'b10, 0, 12'h010, 32'h0, 0, 32'hA5ADBEEF, 4'b0000, 32'h0);
    txn("lb0", 0, 2'b00, 0, 12'h010, 32'h0, 0, 32'hFFFFFFEF, 4'b0000, 32'h0);
    txn("lbu1",0, 2'b00, 1, 12'h011, 32'h0, 0, 32'h000000BE, 4'b0000, 32'h0);
    txn("lh0", 0, 2'b01, 0, 12'h010, 32'h0, 0, 32'hFFFFBEEF, 4'b0000, 32'h0);
    // Errors
    txn("e_lw",  0, 2'b10, 0, 12'h011, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    txn("e_lh",  0, 2'b01, 0, 12'h013, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    txn("e_sz",  0, 2'b11, 0, 12'h010, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    txn("e_sw",  1, 2'b10, 0, 12'h012, 32'h11111111, 1, 32'h0, 4'b0000, 32'h0);
    txn("lw_chk",0, 2'b10, 0, 12'h010, 32'h0, 0, 32'hA5ADBEEF, 4'b0000, 32'h0);

    // Backpressure on a load response with a store waiting
    resp_ready = 1'b0;
    drive(0, 2'b10, 0, 12'h010, 32'h0);
    @(negedge clk);
    chk("bp_accept", {31'b0, req_ready}, 32'd1);
    exp_q.push_back({1'b0, 32'hA5ADBEEF});
    @(posedge clk); #1;
    drive(1, 2'b10, 0, 12'h020, 32'h11223344);
    @(negedge clk);
    chk("bp_rdwait_ready", {31'b0, req_ready}, 32'd0);
    chk("bp_rdwait_en", {31'b0, mem_enable}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_rdata", resp_rdata, 32'hA5ADBEEF);
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_en", {31'b0, mem_enable}, 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("bp_next_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_next_en", {31'b0, mem_enable}, 32'd1);
    chk("bp_next_we", {28'b0, mem_we}, 32'hF);
    chk("bp_next_addr", {22'b0, mem_addr}, 32'd8);
    chk("bp_next_din", mem_din, 32'h11223344);
    exp_q.push_back({1'b0, 32'h0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_store_resp", {31'b0, resp_valid}, 32'd1);
    @(posedge clk); #1;

    // Reset during RD_WAIT drops the load
    drive(0, 2'b00, 0, 12'h013, 32'h0);
    @(negedge clk);
    chk("rw_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rw_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rw_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/rip_bram_lsu_port.md
# rip_bram_lsu_port

Load/store front end that drives the read/write port (port 1) of the 2-read 1-write byte-writable BRAM and serves the CPU memory stage. Accepts one byte/half/word load or store per transaction over a valid/ready request channel. Converts it into word address, byte write-enables and lane-replicated write data. Returns aligned, sign- or zero-extended load data over a valid/ready response channel. Misaligned or illegal-size requests are flagged without touching memory.

## Interface
- ADDR_WIDTH, 10, BRAM word-address width; byte address is ADDR_WIDTH+2 bits
- DATA_WIDTH, 32, fixed at 32; 4 byte lanes of 8 bits
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  ADDR_WIDTH+2  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid & resp_ready
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal size
- mem_enable  out  1  BRAM port-1 enable
- mem_addr  out  ADDR_WIDTH  BRAM word address = req_addr[ADDR_WIDTH+1:2]
- mem_we  out  4  BRAM byte write-enables
- mem_din  out  32  BRAM write data
- mem_dout  in  32  BRAM read data, valid one cycle after mem_enable

## Operation
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE
  - req_ready = 1.
  - mem_* outputs are driven combinationally from the request, qualified by req_valid. Otherwise all mem_* = 0.
- Error check on accept:
  - size 11: error.
  - Half with addr[0]=1: error.
  - Word with addr[1:0]≠0: error.
  - On error: mem_enable=0, mem_we=0; latch resp_err=1, resp_rdata=0; go RESP.
- Store accept:
  - mem_enable=1.
  - mem_we: byte → 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111.
  - mem_din: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
  - Latch resp_err=0, resp_rdata=0; go RESP.
- Load accept:
  - mem_enable=1, mem_we=0.
  - Latch addr[1:0], size and unsigned; go RD_WAIT.
- RD_WAIT
  - req_ready=0, mem_enable=0.
  - Select the lane from mem_dout: byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits per unsigned. Register into resp_rdata with resp_err=0; go RESP.
- RESP
  - req_ready=0; resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_ready=1, then go IDLE.
- One outstanding transaction at most. Requests are not accepted in RD_WAIT or RESP.

## Timing
- Reset values: state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latched fields 0. mem_enable, mem_we and mem_din are 0 while rst=1. req_ready is 0 while rst=1.
- Load accepted in cycle N:
  - mem_enable high in N.
  - mem_dout sampled in N+1.
  - resp_valid from N+2.
  - Minimum 3 cycles per load.
- Store or error accepted in cycle N:
  - Write commits at the end of N.
  - resp_valid from N+1.
  - Minimum 2 cycles per transaction.
- Back-to-back: a new request may be accepted in the cycle after the RESP handshake, with no gap beyond IDLE.
- Reset asserted in RD_WAIT or RESP: the pending transaction is dropped and no response is emitted. A write already committed stays in memory.
- resp_valid never drops without resp_ready. Output data is stable while resp_valid=1.

## Test plan
- Store word 0xDEADBEEF at byte addr 0x010:
  - In the accept cycle: mem_addr=4, mem_we=1111, mem_din=0xDEADBEEF.
  - Next cycle: resp_valid=1, resp_err=0, resp_rdata=0.
- Store byte 0xA5 at 0x013:
  - mem_we=1000, mem_din=0xA5A5A5A5, mem_addr=4.
  - Store half 0x1234 at 0x012: mem_we=1100, mem_din=0x12341234.
- With word 4 = 0xA5ADBEEF, loads:
  - lb 0x013 → 0xFFFFFFA5; lbu 0x013 → 0x000000A5.
  - lh 0x012 → 0xFFFFA5AD; lhu 0x012 → 0x0000A5AD.
  - lw 0x010 → 0xA5ADBEEF.
  - Each response appears 2 cycles after accept.
- Errors: lw at 0x011, lh at 0x013 and size=11 each give no mem_enable, then resp_err=1 and resp_rdata=0 one cycle after accept.
- Backpressure: hold resp_ready=0 for 3 cycles on a load response.
  - resp_valid and resp_rdata stay constant, req_ready=0, and a waiting request is not accepted.
  - The request is accepted in the cycle after the handshake.
- Assert rst in the RD_WAIT cycle of a load: the next cycle is IDLE, resp_valid=0, req_ready=1, and no response is ever produced.
